// File: rtl/chip_pkg.sv
// Shared types and constants for the Sobel edge-detection core.
// Both the top (chip) and the combinational sobel_unit import this package.
package chip_pkg;

    localparam int PIX_W    = 5;
    localparam int IMG      = 20;
    localparam int LANES    = 5;
    localparam int THRESH   = 8;
    localparam int OUT_SIDE = IMG - 2;
    localparam int OUT_N    = OUT_SIDE * OUT_SIDE;
    localparam int LOAD_N   = (IMG * IMG) / LANES;
    localparam int BANDS    = IMG / LANES;

    typedef enum logic [1:0] {
        S_LOAD     = 2'd0,
        S_WAIT_END = 2'd1,
        S_CALC     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [1:0] ANG_0   = 2'd0;
    localparam logic [1:0] ANG_45  = 2'd1;
    localparam logic [1:0] ANG_90  = 2'd2;
    localparam logic [1:0] ANG_135 = 2'd3;

    // Gradients are bounded to +/-124, so the magnitude always fits in 7 bits.
    function automatic logic [6:0] abs8(input logic signed [7:0] v);
        logic [7:0] w_neg;
        w_neg = 8'(-v);
        return v[7] ? w_neg[6:0] : v[6:0];
    endfunction

endpackage

// File: rtl/chip_sobel_unit.sv
// Combinational 3x3 Sobel kernel: nine pixels in (row-major window),
// truncated L1 magnitude and quantized direction out.
module sobel_unit
    import chip_pkg::*;
(
    input  logic [PIX_W-1:0] i_win [9],
    output logic [PIX_W-1:0] o_mag,
    output logic [1:0]       o_ang
);

    function automatic logic [7:0] wsum(input logic [PIX_W-1:0] a,
                                        input logic [PIX_W-1:0] b,
                                        input logic [PIX_W-1:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    logic signed [7:0] w_gx;
    logic signed [7:0] w_gy;
    logic [6:0]        w_ax;
    logic [6:0]        w_ay;
    logic [7:0]        w_sum;
    logic [9:0]        w_ax2;
    logic [9:0]        w_ax5;
    logic [9:0]        w_ay2;
    logic [9:0]        w_ay5;

    assign w_gx  = wsum(i_win[2], i_win[5], i_win[8]) - wsum(i_win[0], i_win[3], i_win[6]);
    assign w_gy  = wsum(i_win[6], i_win[7], i_win[8]) - wsum(i_win[0], i_win[1], i_win[2]);
    assign w_ax  = abs8(w_gx);
    assign w_ay  = abs8(w_gy);
    assign w_sum = {1'b0, w_ax} + {1'b0, w_ay};
    assign o_mag = w_sum[7:3];

    // Ratio tests 5*ay vs 2*ax approximate tan(22.5) / tan(67.5) without division.
    assign w_ax2 = {2'b00, w_ax, 1'b0};
    assign w_ay2 = {2'b00, w_ay, 1'b0};
    assign w_ax5 = {3'b000, w_ax} + {1'b0, w_ax, 2'b00};
    assign w_ay5 = {3'b000, w_ay} + {1'b0, w_ay, 2'b00};

    always_comb begin
        o_ang = ANG_0;
        if (w_ay5 <= w_ax2) begin
            o_ang = ANG_0;
        end else if (w_ay2 >= w_ax5) begin
            o_ang = ANG_90;
        end else if ((w_gx != 8'sd0) && (w_gy != 8'sd0) && (w_gx[7] == w_gy[7])) begin
            o_ang = ANG_45;
        end else begin
            o_ang = ANG_135;
        end
    end

endmodule

// File: rtl/chip.sv
// Sobel edge-detection top: banded 5-lane image load, raster CALC sweep, registered outputs.
// Define CHIP_DEBUG_EN to drive debug_pixel / debug_angle; otherwise they are tied to 0.
//
// state      | meaning
// S_LOAD     | capture one 5-row column slice per cycle (80 samples)
// S_WAIT_END | image complete, waiting for load_end
// S_CALC     | one interior position per cycle, 324 results
// S_DONE     | idle with outputs cleared until reset
module chip
    import chip_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pixel_in0,
    input  logic [PIX_W-1:0] pixel_in1,
    input  logic [PIX_W-1:0] pixel_in2,
    input  logic [PIX_W-1:0] pixel_in3,
    input  logic [PIX_W-1:0] pixel_in4,
    input  logic             load_end,
    output logic             edge_out,
    output logic             readable,
    output logic [PIX_W-1:0] debug_pixel,
    output logic [1:0]       debug_angle
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PIX_W-1:0] r_img [IMG][IMG];
    logic [PIX_W-1:0] w_lane [LANES];
    logic [1:0]       r_ld_band;
    logic [4:0]       r_ld_col;
    logic [4:0]       r_pr;
    logic [4:0]       r_pc;
    logic [4:0]       w_base_row;
    logic             w_capture;
    logic             w_calc;
    logic             w_load_last;
    logic             w_calc_last;
    logic [PIX_W-1:0] w_win [9];
    logic [PIX_W-1:0] w_mag;
    logic [1:0]       w_ang;
    logic             r_readable;
    logic             r_edge;

    assign w_lane[0] = pixel_in0;
    assign w_lane[1] = pixel_in1;
    assign w_lane[2] = pixel_in2;
    assign w_lane[3] = pixel_in3;
    assign w_lane[4] = pixel_in4;

    assign w_base_row  = {3'b000, r_ld_band} * 5'd5;
    assign w_load_last = (r_ld_band == 2'(BANDS - 1)) && (r_ld_col == 5'(IMG - 1));
    assign w_calc_last = (r_pr == 5'(OUT_SIDE - 1)) && (r_pc == 5'(OUT_SIDE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_calc      = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_capture = 1'b1;
                if (w_load_last) begin
                    w_state_nxt = load_end ? S_CALC : S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (load_end) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_calc = 1'b1;
                if (w_calc_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_band <= '0;
            r_ld_col  <= '0;
            r_pr      <= '0;
            r_pc      <= '0;
        end else begin
            if (w_capture) begin
                if (r_ld_col == 5'(IMG - 1)) begin
                    r_ld_col  <= '0;
                    r_ld_band <= r_ld_band + 2'd1;
                end else begin
                    r_ld_col <= r_ld_col + 5'd1;
                end
            end
            if (w_calc) begin
                if (r_pc == 5'(OUT_SIDE - 1)) begin
                    r_pc <= '0;
                    r_pr <= r_pr + 5'd1;
                end else begin
                    r_pc <= r_pc + 5'd1;
                end
            end
        end
    end

    // Image buffer carries no reset; it is fully rewritten before any CALC pass.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < LANES; k++) begin
                r_img[w_base_row + 5'(k)][r_ld_col] <= w_lane[k];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            w_win[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_win[i*3 + j] = r_img[r_pr + 5'(i)][r_pc + 5'(j)];
            end
        end
    end

    sobel_unit u_sobel (
        .i_win (w_win),
        .o_mag (w_mag),
        .o_ang (w_ang)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readable <= 1'b0;
            r_edge     <= 1'b0;
        end else begin
            r_readable <= w_calc;
            r_edge     <= w_calc && (w_mag >= 5'(THRESH));
        end
    end

    assign readable = r_readable;
    assign edge_out = r_edge;

`ifdef CHIP_DEBUG_EN
    logic [PIX_W-1:0] r_dbg_mag;
    logic [1:0]       r_dbg_ang;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dbg_mag <= '0;
            r_dbg_ang <= '0;
        end else begin
            r_dbg_mag <= w_calc ? w_mag : '0;
            r_dbg_ang <= w_calc ? w_ang : '0;
        end
    end

    assign debug_pixel = r_dbg_mag;
    assign debug_angle = r_dbg_ang;
`else
    logic w_unused_ang;
    assign w_unused_ang = ^w_ang;
    assign debug_pixel  = '0;
    assign debug_angle  = '0;
`endif

endmodule

// File: tb/tb_chip.sv
// Self-checking bench for chip: directed Sobel patterns plus random images,
// compared against an arithmetic window model kept in the bench.
module tb_chip;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_end = 1'b0;
    logic [4:0] pixel_in0 = '0;
    logic [4:0] pixel_in1 = '0;
    logic [4:0] pixel_in2 = '0;
    logic [4:0] pixel_in3 = '0;
    logic [4:0] pixel_in4 = '0;
    logic       edge_out;
    logic       readable;
    logic [4:0] debug_pixel;
    logic [1:0] debug_angle;

    int img [20][20];
    int cap_edge [324];
    int cap_mag [324];
    int cap_ang [324];
    int n_checks = 0;
    int n_pass = 0;

    chip dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_in0   (pixel_in0),
        .pixel_in1   (pixel_in1),
        .pixel_in2   (pixel_in2),
        .pixel_in3   (pixel_in3),
        .pixel_in4   (pixel_in4),
        .load_end    (load_end),
        .edge_out    (edge_out),
        .readable    (readable),
        .debug_pixel (debug_pixel),
        .debug_angle (debug_angle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Expected results straight from the Sobel definition on the bench image.
    function automatic void model(input int n, output int mag, output int ang, output int edg);
        int r, c, gx, gy, ax, ay;
        r  = n / 18 + 1;
        c  = n % 18 + 1;
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        ax  = iabs(gx);
        ay  = iabs(gy);
        mag = (ax + ay) / 8;
        if (5*ay <= 2*ax)                             ang = 0;
        else if (2*ay >= 5*ax)                        ang = 2;
        else if (gx != 0 && gy != 0 && (gx > 0) == (gy > 0)) ang = 1;
        else                                          ang = 3;
        edg = (mag >= 8) ? 1 : 0;
    endfunction

    function automatic int idx(input int r, input int c);
        return (r - 1) * 18 + (c - 1);
    endfunction

    task automatic garbage();
        pixel_in0 = 5'($urandom_range(0, 31));
        pixel_in1 = 5'($urandom_range(0, 31));
        pixel_in2 = 5'($urandom_range(0, 31));
        pixel_in3 = 5'($urandom_range(0, 31));
        pixel_in4 = 5'($urandom_range(0, 31));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        load_end = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++)
                img[r][c] = int'($urandom_range(0, 31));
    endtask

    // Leaves the caller just after the edge on which CALC is entered.
    task automatic load_image(input int hold);
        for (int t = 0; t < 80; t++) begin
            pixel_in0 = 5'(img[5*(t/20) + 0][t%20]);
            pixel_in1 = 5'(img[5*(t/20) + 1][t%20]);
            pixel_in2 = 5'(img[5*(t/20) + 2][t%20]);
            pixel_in3 = 5'(img[5*(t/20) + 3][t%20]);
            pixel_in4 = 5'(img[5*(t/20) + 4][t%20]);
            if (t == 79) load_end = (hold == 0);
            else         load_end = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        for (int h = 0; h < hold; h++) begin
            garbage();
            load_end = 1'b0;
            @(negedge clk);
            chk("wait_readable", int'(readable), 0);
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            load_end = 1'b1;
            @(posedge clk);
            #1;
        end
        garbage();
        load_end = 1'($urandom_range(0, 1));
    endtask

    task automatic collect(input string name, input int abort_at);
        int m, a, e;
        @(negedge clk);
        chk({name, "_lat0_readable"}, int'(readable), 0);
        for (int n = 0; n < 324; n++) begin
            garbage();
            load_end = 1'($urandom_range(0, 1));
            @(negedge clk);
            model(n, m, a, e);
            cap_edge[n] = int'(edge_out);
            cap_mag[n]  = int'(debug_pixel);
            cap_ang[n]  = int'(debug_angle);
            chk({name, "_readable"}, int'(readable), 1);
            chk($sformatf("%s_edge[%0d]", name, n), int'(edge_out), e);
`ifdef CHIP_DEBUG_EN
            chk($sformatf("%s_mag[%0d]", name, n), int'(debug_pixel), m);
            chk($sformatf("%s_ang[%0d]", name, n), int'(debug_angle), a);
`else
            chk($sformatf("%s_mag_tied[%0d]", name, n), int'(debug_pixel), 0);
            chk($sformatf("%s_ang_tied[%0d]", name, n), int'(debug_angle), 0);
`endif
            if (n == abort_at) begin
                #2 reset = 1'b0;
                #1;
                chk({name, "_async_readable"}, int'(readable), 0);
                chk({name, "_async_edge"}, int'(edge_out), 0);
                return;
            end
        end
        repeat (3) begin
            @(negedge clk);
            chk({name, "_done_readable"}, int'(readable), 0);
            chk({name, "_done_edge"}, int'(edge_out), 0);
            chk({name, "_done_mag"}, int'(debug_pixel), 0);
            chk({name, "_done_ang"}, int'(debug_angle), 0);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #2;
        chk("rst_readable", int'(readable), 0);
        chk("rst_edge", int'(edge_out), 0);
        chk("rst_mag", int'(debug_pixel), 0);
        chk("rst_ang", int'(debug_angle), 0);

        // flat image
        for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) img[r][c] = 17;
        do_reset(); load_image(0); collect("flat", -1);

        // vertical step
        for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) img[r][c] = (c < 10) ? 0 : 31;
        do_reset(); load_image(0); collect("vstep", -1);
        chk("vstep_edge_r5c9", cap_edge[idx(5, 9)], 1);
        chk("vstep_edge_r5c5", cap_edge[idx(5, 5)], 0);
`ifdef CHIP_DEBUG_EN
        chk("vstep_mag_r5c9", cap_mag[idx(5, 9)], 15);
        chk("vstep_ang_r5c9", cap_ang[idx(5, 9)], 0);
        chk("vstep_mag_r5c5", cap_mag[idx(5, 5)], 0);
`endif

        // horizontal step
        for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) img[r][c] = (r < 10) ? 0 : 31;
        do_reset(); load_image(0); collect("hstep", -1);
        chk("hstep_edge_r9c4", cap_edge[idx(9, 4)], 1);
`ifdef CHIP_DEBUG_EN
        chk("hstep_mag_r9c4", cap_mag[idx(9, 4)], 15);
        chk("hstep_ang_r9c4", cap_ang[idx(9, 4)], 2);
`endif

        // diagonal ramps (wrap to 5 bits far from the checked corner)
        for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) img[r][c] = (r + c) % 32;
        do_reset(); load_image(0); collect("ramp45", -1);
        chk("ramp45_edge_r3c3", cap_edge[idx(3, 3)], 0);
`ifdef CHIP_DEBUG_EN
        chk("ramp45_mag_r3c3", cap_mag[idx(3, 3)], 2);
        chk("ramp45_ang_r3c3", cap_ang[idx(3, 3)], 1);
`endif
        for (int r = 0; r < 20; r++) for (int c = 0; c < 20; c++) img[r][c] = (19 + r - c) % 32;
        do_reset(); load_image(0); collect("ramp135", -1);
        chk("ramp135_edge_r3c3", cap_edge[idx(3, 3)], 0);
`ifdef CHIP_DEBUG_EN
        chk("ramp135_ang_r3c3", cap_ang[idx(3, 3)], 3);
`endif

        // load_end held low for 10 cycles
        fill_random();
        do_reset(); load_image(10); collect("hold10", -1);

        // reset in the middle of CALC, then a full reload
        fill_random();
        do_reset(); load_image(0); collect("abort", 100);
        @(negedge clk);
        chk("abort_held_readable", int'(readable), 0);
        fill_random();
        do_reset(); load_image(0); collect("reload", -1);

        for (int k = 0; k < 3; k++) begin
            fill_random();
            do_reset();
            load_image(int'($urandom_range(0, 5)));
            collect($sformatf("rand%0d", k), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chip.md
# chip

Top-level edge-detection core: loads a 20×20 image of 5-bit pixels through five parallel row lanes, then computes a 3×3 Sobel gradient over the 18×18 interior. Interior pixels are processed in raster order, one per cycle. It produces a thresholded edge bit plus debug magnitude and angle streams. It sits between the off-chip pixel loader and the edge-map consumer.

## Interface
- `PIX_W`, 5: pixel / magnitude width.
- `IMG`, 20: image side length; output side is `IMG-2` = 18.
- `LANES`, 5: rows delivered per load cycle.
- `THRESH`, 8: edge threshold on the magnitude.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `pixel_in0`…`pixel_in4` in 5 each: lane K carries row `5*band+K`.
- `edge_out` out 1: 1 when the current magnitude ≥ `THRESH`; valid with `readable`.
- `load_end` in 1: loader signals input complete.
- `readable` out 1: output-valid strobe.
- `debug_pixel` out 5: gradient magnitude.
- `debug_angle` out 2: quantized gradient direction.

## Operation
- States: `LOAD` → `WAIT_END` → `CALC` → `DONE`.
- `LOAD`: one sample per rising edge, starting at the first edge after reset release.
  - For sample t (0..79): band = t/20, col = t%20.
  - `pixel_inK` is stored to `img[5*band+K][col]`.
- After sample 79 is captured:
  - If `load_end` is 1 at that edge, go to `CALC`.
  - Otherwise go to `WAIT_END`: no capture, stay until `load_end`=1, then go to `CALC`.
- `CALC`: visit r = 1..18 outer, c = 1..18 inner, one position per cycle (324 total), over window `img[r-1..r+1][c-1..c+1]`.
  - Gx = (right column) − (left column), weights 1,2,1.
  - Gy = (bottom row) − (top row), weights 1,2,1.
  - Gx and Gy are signed 8-bit; range ±124.
- Magnitude = (|Gx| + |Gy|) >> 3, truncating; maximum 31, so it fits 5 bits with no saturation needed.
- Angle, with ax = |Gx| and ay = |Gy|:
  - 0 if 5·ay ≤ 2·ax;
  - else 2 if 2·ay ≥ 5·ax;
  - else 1 if Gx and Gy are both nonzero with equal sign;
  - else 3.
  - Gx = Gy = 0 gives 0.
- `DONE`: `readable`=0 and all outputs 0. Only reset leaves `DONE`.

## Timing
- Reset values: `readable`, `edge_out`, `debug_pixel`, `debug_angle` all 0; state `LOAD`; counters 0. The image buffer need not be reset.
- Outputs are registered. Result n (raster index 0..323) is presented in the n-th cycle after the `CALC` entry edge, with `readable`=1 for exactly 324 consecutive cycles.
- Outputs are stable for a full cycle; the consumer samples at the falling edge.
- Reset asserted mid-operation aborts immediately and the next load restarts at sample 0.
- Inputs during `CALC` and `DONE` are ignored.

## Configuration
- `CHIP_DEBUG_EN` defined: `debug_pixel` and `debug_angle` are driven as specified.
- `CHIP_DEBUG_EN` undefined: both are tied to 0. `edge_out` and `readable` are unchanged, and the magnitude path remains internally for the threshold compare.

## Structure
- Package `chip_pkg`:
  - state enum;
  - angle codes `ANG_0`, `ANG_45`, `ANG_90`, `ANG_135` (0..3);
  - `IMG`, `LANES`, `OUT_N` = 324, `LOAD_N` = 80.
- Sub-module `sobel_unit`: purely combinational; takes nine 5-bit pixels and returns magnitude and angle. The top holds the buffer, counters, FSM and output registers.

## Test plan
- Flat image (all pixels 17), `load_end` high with sample 79:
  - exactly 324 `readable` cycles, all magnitude 0, angle 0, `edge_out` 0.
- Vertical step (columns 0–9 = 0, columns 10–19 = 31):
  - at r=5, c=9: Gx = 124, Gy = 0, magnitude 15, angle 0, `edge_out` 1;
  - at c=5: magnitude 0.
- Horizontal step (rows 0–9 = 0, rows 10–19 = 31):
  - at row 9: magnitude 15, angle 2.
- Diagonal ramp with pixel = row + col:
  - Gx = Gy = 8, magnitude 2, angle 1.
  - With pixel = 19 + row − col: Gy = 8, Gx = −8, angle 3.
- Hold `load_end` low for 10 cycles after sample 79:
  - no `readable` until the cycle after `load_end` is seen;
  - results are still correct.
- Assert `reset` low during `CALC` at output 100:
  - `readable` drops asynchronously;
  - a full reload then yields all 324 outputs again.
